hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 141 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Per-register pending-write counters gating instruction issue on
//            RAW hazards, per-register depth and total in-flight capacity.
// Revision : 1.0  initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int NREGS  = 16,
    parameter int AW     = 4,
    parameter int NSRC   = 3,
    parameter int CW     = 2,
    parameter int MAXINF = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           issue_valid,
    output logic                           issue_ready,
    input  logic [NSRC*AW-1:0]             src_addr,
    input  logic [NSRC-1:0]                src_en,
    input  logic [AW-1:0]                  iss_rd0,
    input  logic [AW-1:0]                  iss_rd1,
    input  logic                           iss_rd0_en,
    input  logic                           iss_rd1_en,
    input  logic                           wb_valid,
    input  logic [AW-1:0]                  wb_rd0,
    input  logic [AW-1:0]                  wb_rd1,
    input  logic                           wb_rd0_en,
    input  logic                           wb_rd1_en,
    input  logic                           flush,
    output logic [NREGS-1:0]               busy,
    output logic [$clog2(MAXINF+1)-1:0]    inflight,
    output logic                           err_underflow
);

    localparam int            c_TW   = $clog2(MAXINF+1);
    localparam logic [CW-1:0] c_CMAX = '1;

    logic [CW-1:0]   r_cnt [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [c_TW-1:0] r_inflight;
    logic            r_err;

    logic [CW-1:0]   w_cnt_nxt [NREGS];
    logic [NREGS-1:0] w_dec;
    logic [NREGS-1:0] w_incq;
    logic [NREGS-1:0] w_blk;
    logic            w_src_haz;
    logic            w_dst_lim;
    logic            w_cap_lim;
    logic            w_ready;
    logic            w_fire;
    logic            w_uf;
    int              w_proj_sum;
    int              w_sum_nxt;

    // Out-of-range addresses never match an index below NREGS, so they are ignored.
    function automatic logic f_hit(input logic en, input logic [AW-1:0] a, input int idx);
        return en && (int'(a) == idx);
    endfunction

    // Simultaneous increment and decrement cancel; decrement of zero saturates.
    function automatic logic [CW-1:0] f_next(input logic [CW-1:0] cnt, input logic inc,
                                             input logic dec);
        logic [CW-1:0] v;
        v = cnt;
        if (inc && !dec)
            v = cnt + CW'(1);
        else if (dec && !inc && cnt != '0)
            v = cnt - CW'(1);
        return v;
    endfunction

    always_comb begin
        w_dec      = '0;
        w_incq     = '0;
        w_blk      = '0;
        w_src_haz  = 1'b0;
        w_dst_lim  = 1'b0;
        w_proj_sum = 0;
        for (int i = 0; i < NREGS; i++) begin
            w_dec[i]  = wb_valid && (f_hit(wb_rd0_en, wb_rd0, i) || f_hit(wb_rd1_en, wb_rd1, i));
            w_incq[i] = f_hit(iss_rd0_en, iss_rd0, i) || f_hit(iss_rd1_en, iss_rd1, i);
            w_blk[i]  = (r_cnt[i] != '0) && !((r_cnt[i] == CW'(1)) && w_dec[i]);
            if (w_incq[i] && (r_cnt[i] == c_CMAX) && !w_dec[i])
                w_dst_lim = 1'b1;
            w_proj_sum = w_proj_sum + int'(f_next(r_cnt[i], w_incq[i], w_dec[i]));
        end
        for (int k = 0; k < NSRC; k++) begin
            for (int i = 0; i < NREGS; i++) begin
                if (f_hit(src_en[k], src_addr[k*AW +: AW], i) && w_blk[i])
                    w_src_haz = 1'b1;
            end
        end
        w_cap_lim = (w_proj_sum > MAXINF);
        w_ready   = !reset && !flush && !w_src_haz && !w_dst_lim && !w_cap_lim;
        w_fire    = issue_valid && w_ready;
    end

    always_comb begin
        w_uf      = 1'b0;
        w_sum_nxt = 0;
        for (int i = 0; i < NREGS; i++) begin
            w_cnt_nxt[i] = f_next(r_cnt[i], w_incq[i] && w_fire, w_dec[i]);
            if (w_dec[i] && (r_cnt[i] == '0) && !(w_incq[i] && w_fire))
                w_uf = 1'b1;
            w_sum_nxt = w_sum_nxt + int'(w_cnt_nxt[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                r_cnt[i] <= '0;
            r_busy     <= '0;
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else if (flush) begin
            // Error flag survives a flush; only pending state is discarded.
            for (int i = 0; i < NREGS; i++)
                r_cnt[i] <= '0;
            r_busy     <= '0;
            r_inflight <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                r_cnt[i]  <= w_cnt_nxt[i];
                r_busy[i] <= (w_cnt_nxt[i] != '0);
            end
            r_inflight <= c_TW'(w_sum_nxt);
            if (w_uf)
                r_err <= 1'b1;
        end
    end

    assign issue_ready   = w_ready;
    assign busy          = r_busy;
    assign inflight      = r_inflight;
    assign err_underflow = r_err;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Directed and random stimulus against a counting reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int NR = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic [11:0] src_addr;
    logic [2:0]  src_en;
    logic [3:0]  iss_rd0, iss_rd1;
    logic        iss_rd0_en, iss_rd1_en;
    logic        wb_valid;
    logic [3:0]  wb_rd0, wb_rd1;
    logic        wb_rd0_en, wb_rd1_en;
    logic        flush;
    logic [NR-1:0] busy;
    logic [2:0]  inflight;
    logic        err_underflow;

    int m_cnt [NR];
    bit m_err;
    int errors = 0;
    int checks = 0;

    hazard_scoreboard #(.NREGS(NR), .AW(4), .NSRC(3), .CW(2), .MAXINF(4)) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .src_addr(src_addr), .src_en(src_en), .iss_rd0(iss_rd0), .iss_rd1(iss_rd1),
        .iss_rd0_en(iss_rd0_en), .iss_rd1_en(iss_rd1_en), .wb_valid(wb_valid),
        .wb_rd0(wb_rd0), .wb_rd1(wb_rd1), .wb_rd0_en(wb_rd0_en), .wb_rd1_en(wb_rd1_en),
        .flush(flush), .busy(busy), .inflight(inflight), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 0; src_addr = '0; src_en = '0;
        iss_rd0 = 0; iss_rd1 = 0; iss_rd0_en = 0; iss_rd1_en = 0;
        wb_valid = 0; wb_rd0 = 0; wb_rd1 = 0; wb_rd0_en = 0; wb_rd1_en = 0;
        flush = 0;
    endtask

    task automatic model_clear();
        for (int r = 0; r < NR; r++) m_cnt[r] = 0;
    endtask

    task automatic check_state(input string tag);
        logic [NR-1:0] eb;
        int es;
        es = 0;
        for (int r = 0; r < NR; r++) begin
            eb[r] = (m_cnt[r] != 0);
            es += m_cnt[r];
        end
        check({tag, "_busy"}, 32'(busy), 32'(eb));
        check({tag, "_inflight"}, 32'(inflight), 32'(es));
        check({tag, "_err"}, 32'(err_underflow), 32'(m_err));
    endtask

    // One clock: predict readiness from the counting rules, then apply the edge.
    task automatic cycle(input string tag);
        bit dst [NR];
        bit wbm [NR];
        bit haz, dlim, exp_rdy, fire, inc, dec;
        int psum, a;
        haz = 0; dlim = 0; psum = 0;
        for (int r = 0; r < NR; r++) begin
            dst[r] = 0; wbm[r] = 0;
        end
        if (iss_rd0_en && iss_rd0 < NR) dst[iss_rd0] = 1;
        if (iss_rd1_en && iss_rd1 < NR) dst[iss_rd1] = 1;
        if (wb_valid && wb_rd0_en && wb_rd0 < NR) wbm[wb_rd0] = 1;
        if (wb_valid && wb_rd1_en && wb_rd1 < NR) wbm[wb_rd1] = 1;
        for (int k = 0; k < 3; k++) begin
            a = int'(src_addr[k*4 +: 4]);
            if (src_en[k] && a < NR && m_cnt[a] != 0 && !(m_cnt[a] == 1 && wbm[a])) haz = 1;
        end
        for (int r = 0; r < NR; r++) begin
            if (dst[r] && m_cnt[r] == 3 && !wbm[r]) dlim = 1;
            psum += m_cnt[r] + (dst[r] ? 1 : 0) - ((wbm[r] && (m_cnt[r] > 0 || dst[r])) ? 1 : 0);
        end
        exp_rdy = !reset && !flush && !haz && !dlim && (psum <= 4);
        fire = issue_valid && exp_rdy;
        #1 check({tag, "_rdy"}, 32'(issue_ready), 32'(exp_rdy));
        @(posedge clk);
        if (flush) begin
            model_clear();
        end else begin
            for (int r = 0; r < NR; r++) begin
                inc = dst[r] && fire;
                dec = wbm[r];
                if (dec && m_cnt[r] == 0 && !inc) m_err = 1;
                m_cnt[r] += (inc ? 1 : 0) - ((dec && (m_cnt[r] > 0 || inc)) ? 1 : 0);
            end
        end
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic issue1(input int rd, input string tag);
        idle(); issue_valid = 1; iss_rd0 = 4'(rd); iss_rd0_en = 1;
        cycle(tag);
    endtask

    task automatic wb1(input int rd, input string tag);
        idle(); wb_valid = 1; wb_rd0 = 4'(rd); wb_rd0_en = 1;
        cycle(tag);
    endtask

    initial begin
        int s;
        model_clear();
        m_err = 0;
        idle();
        reset = 1;
        issue_valid = 1;
        #1;
        check("reset_rdy", 32'(issue_ready), 0);
        check_state("reset");
        @(negedge clk);
        reset = 0;

        // Read-after-write hazard and same-cycle retire bypass.
        issue1(0, "add_r0");
        idle(); issue_valid = 1; src_addr = 12'h000; src_en = 3'b001;
        #1 check("raw_stall", 32'(issue_ready), 0);
        cycle("raw");
        check("raw_busy0", 32'(busy[0]), 1);
        wb_valid = 1; wb_rd0 = 0; wb_rd0_en = 1;
        #1 check("bypass_rdy", 32'(issue_ready), 1);
        cycle("bypass");

        // Long multiply pair.
        idle(); issue_valid = 1; iss_rd0 = 0; iss_rd0_en = 1; iss_rd1 = 1; iss_rd1_en = 1;
        cycle("umull");
        check("umull_inflight", 32'(inflight), 2);
        check("umull_busy", 32'(busy), 32'h3);
        idle(); wb_valid = 1; wb_rd0 = 0; wb_rd0_en = 1; wb_rd1 = 1; wb_rd1_en = 1;
        cycle("umull_wb");
        check("umull_wb_inflight", 32'(inflight), 0);

        // Capacity limit.
        for (int r = 5; r <= 8; r++) issue1(r, "cap_fill");
        idle(); issue_valid = 1; iss_rd0 = 9; iss_rd0_en = 1;
        #1 check("cap_stall", 32'(issue_ready), 0);
        cycle("cap_stall1");
        cycle("cap_stall2");
        wb_valid = 1; wb_rd0 = 5; wb_rd0_en = 1;
        cycle("cap_swap");
        check("cap_inflight", 32'(inflight), 4);
        idle(); wb_valid = 1; wb_rd0 = 6; wb_rd0_en = 1; wb_rd1 = 7; wb_rd1_en = 1;
        cycle("cap_drain1");
        wb_rd0 = 8; wb_rd1 = 9;
        cycle("cap_drain2");

        // Per-register depth limit.
        for (int n = 0; n < 3; n++) issue1(2, "depth_fill");
        idle(); issue_valid = 1; iss_rd0 = 2; iss_rd0_en = 1;
        #1 check("depth_stall", 32'(issue_ready), 0);
        cycle("depth_stall");
        wb_valid = 1; wb_rd0 = 2; wb_rd0_en = 1;
        cycle("depth_swap");
        check("depth_inflight", 32'(inflight), 3);
        idle(); wb_valid = 1; wb_rd0 = 2; wb_rd0_en = 1; wb_rd1 = 2; wb_rd1_en = 1;
        cycle("dup_wb");
        check("dup_wb_inflight", 32'(inflight), 2);
        wb1(2, "depth_drain1");
        wb1(2, "depth_drain2");

        // Duplicate destination counts once; out-of-range addresses ignored.
        idle(); issue_valid = 1; iss_rd0 = 4; iss_rd0_en = 1; iss_rd1 = 4; iss_rd1_en = 1;
        cycle("dup_iss");
        check("dup_iss_inflight", 32'(inflight), 1);
        idle(); issue_valid = 1; iss_rd0 = 13; iss_rd0_en = 1; iss_rd1 = 15; iss_rd1_en = 1;
        src_addr = 12'h0E4; src_en = 3'b011;
        cycle("oor");
        idle(); issue_valid = 1; src_addr = 12'h00E; src_en = 3'b001;
        wb_valid = 1; wb_rd0 = 14; wb_rd0_en = 1; wb_rd1 = 4; wb_rd1_en = 1;
        cycle("oor_wb");
        check("oor_err", 32'(err_underflow), 0);

        // Underflow is sticky across flush.
        wb1(7, "uflow");
        check("uflow_err", 32'(err_underflow), 1);
        issue1(1, "pre_flush1");
        issue1(3, "pre_flush2");
        idle(); flush = 1; issue_valid = 1; iss_rd0 = 5; iss_rd0_en = 1;
        wb_valid = 1; wb_rd0 = 3; wb_rd0_en = 1;
        cycle("flush");
        check("flush_err", 32'(err_underflow), 1);

        // Asynchronous reset mid-flight.
        issue1(1, "rst_fill1");
        issue1(2, "rst_fill2");
        issue1(3, "rst_fill3");
        check("rst_pre_inflight", 32'(inflight), 3);
        idle(); issue_valid = 1;
        #2 reset = 1;
        #1;
        model_clear();
        m_err = 0;
        check("async_rst_rdy", 32'(issue_ready), 0);
        check_state("async_rst");
        @(negedge clk);
        reset = 0;
        issue1(6, "post_rst_issue");
        wb1(1, "stale_wb");
        check("stale_wb_err", 32'(err_underflow), 1);
        wb1(6, "post_rst_drain");

        // Random traffic with mostly well-formed write-backs.
        for (int n = 0; n < 400; n++) begin
            idle();
            issue_valid = ($urandom_range(0, 3) != 0);
            src_addr    = 12'($urandom);
            src_en      = 3'($urandom);
            iss_rd0     = 4'($urandom_range(0, 13));
            iss_rd0_en  = 1'($urandom);
            iss_rd1     = 4'($urandom_range(0, 13));
            iss_rd1_en  = ($urandom_range(0, 3) == 0);
            wb_valid    = 1'($urandom);
            s = $urandom_range(0, NR - 1);
            wb_rd0 = 4'(s);
            for (int j = 0; j < NR; j++) begin
                if (m_cnt[(s + j) % NR] != 0) begin
                    wb_rd0 = 4'((s + j) % NR);
                    break;
                end
            end
            wb_rd0_en = 1;
            wb_rd1    = 4'($urandom_range(0, NR - 1));
            wb_rd1_en = ($urandom_range(0, 7) == 0) && (m_cnt[wb_rd1] != 0);
            flush     = ($urandom_range(0, 49) == 0);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
